mod_updown_counter: RTL

Parametrised up/down modulo counter, the general-purpose successor to the fixed 4-bit free-running counter. Adds configurable width and modulus, direction control, count enable, synchronous clear and parallel load, wrap or one-shot mode, and terminal-count, wrap and done status outputs. Used wherever the design needs a programmable tick divider, event counter or timeout.

---
 rtl/mod_updown_counter.sv | 101 ++++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_updown_counter
// Brief    : Parametrised up/down modulo counter with enable, synchronous
//            clear, clamped parallel load, wrap / one-shot modes and
//            terminal-count, wrap and done status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mod_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  // Highest legal count and unit step, sized to the counter.
  localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Two-state control: RUN counts, HALT freezes until clear/load/reset.
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [WIDTH-1:0] r_count;
  logic [0:0]       r_state;
  logic             r_wrap;

  logic [WIDTH-1:0] w_term;
  logic             w_tc;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_nxt;
  logic [0:0]       w_state_nxt;
  logic             w_wrap_nxt;

  // Terminal value follows the live direction input; tc ignores en and state.
  always_comb begin
    w_term         = up_dn ? c_MAX : c_ZERO;
    w_tc           = (r_count == w_term);
    w_load_clamped = (load_val > c_MAX) ? c_MAX : load_val;
  end

  // Next-state selection in priority order clear > load > HALT hold > enable.
  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    if (clear) begin
      w_count_nxt = c_ZERO;
      w_state_nxt = S_RUN;
    end else if (load) begin
      w_count_nxt = w_load_clamped;
      w_state_nxt = S_RUN;
    end else if (r_state == S_RUN && en) begin
      if (!w_tc) begin
        w_count_nxt = up_dn ? (r_count + c_ONE) : (r_count - c_ONE);
      end else if (!one_shot) begin
        // Wrap explicitly rather than relying on 2**WIDTH rollover, so a
        // modulus below 2**WIDTH stays in range.
        w_count_nxt = up_dn ? c_ZERO : c_MAX;
        w_wrap_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_HALT;
      end
    end
  end

  // State registers; reset asserts asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= c_ZERO;
      r_state <= S_RUN;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Output mapping; done is the registered HALT state itself.
  always_comb begin
    count = r_count;
    tc    = w_tc;
    wrap  = r_wrap;
    done  = (r_state == S_HALT);
  end

endmodule
`default_nettype wire
